// File: rtl/exec_pkg.sv
// ============================================================================
// Module   : exec_pkg
// Brief    : Op-code and multiplier FSM encodings shared by the execute stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package exec_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_SLT   = 4'd5,
        OP_SLL   = 4'd6,
        OP_SRL   = 4'd7,
        OP_SRA   = 4'd8,
        OP_PASSB = 4'd9,
        OP_MUL   = 4'd10
    } op_e;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } mul_state_e;

    localparam int c_IMM_W     = 16;
    // Holds MUL_LAT-1 for the full supported latency range 1..8.
    localparam int c_MUL_CNT_W = 3;

endpackage

`default_nettype wire

// File: rtl/exec_if.sv
// ============================================================================
// Module   : exec_if
// Brief    : Issue/result handshake bundle between decode, execute and writeback.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface exec_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0]            op;
    logic [REG_ADDR_W-1:0] rs_a_addr;
    logic [REG_ADDR_W-1:0] rs_b_addr;
    logic [XLEN-1:0]       rs_a_data;
    logic [XLEN-1:0]       rs_b_data;
    logic [15:0]           imm;
    logic                  is_imm;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  flush;
    logic                  out_valid;
    logic                  out_ready;
    logic [XLEN-1:0]       out_d_data;
    logic [XLEN-1:0]       out_b_data;
    logic                  out_zero;
    logic [REG_ADDR_W-1:0] out_rd;
    logic                  busy;

    modport master (
        output in_valid, op, rs_a_addr, rs_b_addr, rs_a_data, rs_b_data,
               imm, is_imm, rd_addr, flush, out_ready,
        input  in_ready, out_valid, out_d_data, out_b_data, out_zero,
               out_rd, busy
    );

    modport slave (
        input  in_valid, op, rs_a_addr, rs_b_addr, rs_a_data, rs_b_data,
               imm, is_imm, rd_addr, flush, out_ready,
        output in_ready, out_valid, out_d_data, out_b_data, out_zero,
               out_rd, busy
    );

endinterface

`default_nettype wire

// File: rtl/exec_mul.sv
// ============================================================================
// Module   : exec_mul
// Brief    : Fixed-latency multiplier; busy for MUL_LAT cycles after i_start,
//            o_done pulses during the last busy cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module exec_mul
    import exec_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_p
);

    localparam logic [c_MUL_CNT_W-1:0] c_CNT_LAST = c_MUL_CNT_W'(MUL_LAT - 1);

    mul_state_e               r_state;
    mul_state_e               w_state_nxt;
    logic [c_MUL_CNT_W-1:0]   r_cnt;
    logic [XLEN-1:0]          r_a;
    logic [XLEN-1:0]          r_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start && !i_flush) begin
                    w_state_nxt = ST_MUL_BUSY;
                end
            end
            ST_MUL_BUSY: begin
                if (i_flush) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == '0) begin
                    o_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operands are captured once so the register file may move on during the multiply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_a   <= '0;
            r_b   <= '0;
        end else if (r_state == ST_IDLE && i_start) begin
            r_cnt <= c_CNT_LAST;
            r_a   <= i_a;
            r_b   <= i_b;
        end else if (r_state == ST_MUL_BUSY && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_busy = (r_state == ST_MUL_BUSY);
    assign o_p    = r_a * r_b;

endmodule

`default_nettype wire

// File: rtl/exec_stage.sv
// ============================================================================
// Module   : exec_stage
// Brief    : Single-issue execute stage: 1-cycle ALU plus multi-cycle multiply
//            behind a valid/ready result register. Optional result forwarding
//            is enabled by defining EXEC_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module exec_stage
    import exec_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int MUL_LAT    = 3
) (
    input  logic   clk,
    input  logic   rst_n,
    exec_if.slave  bus
);

    localparam int c_SH_W = $clog2(XLEN);

    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_is_mul;
    logic                  w_mul_start;
    logic                  w_mul_busy;
    logic                  w_mul_done;
    logic [XLEN-1:0]       w_mul_p;
    logic [XLEN-1:0]       w_op_a;
    logic [XLEN-1:0]       w_b_raw;
    logic [XLEN-1:0]       w_op_b;
    logic [XLEN-1:0]       w_imm_ext;
    logic [XLEN-1:0]       w_alu;
    logic [c_SH_W-1:0]     w_shamt;

    logic                  r_out_valid;
    logic                  r_out_zero;
    logic [XLEN-1:0]       r_out_d;
    logic [XLEN-1:0]       r_out_b;
    logic [REG_ADDR_W-1:0] r_out_rd;
    logic [XLEN-1:0]       r_pend_b;
    logic [REG_ADDR_W-1:0] r_pend_rd;

    // ---------------------------------------------------------------- operands
`ifdef EXEC_BYPASS_EN
    logic w_byp_a;
    logic w_byp_b;

    // r0 is hard-wired zero in the register file, so it never forwards.
    assign w_byp_a = r_out_valid && (bus.rs_a_addr != '0) && (bus.rs_a_addr == r_out_rd);
    assign w_byp_b = r_out_valid && (bus.rs_b_addr != '0) && (bus.rs_b_addr == r_out_rd);
    assign w_op_a  = w_byp_a ? r_out_d : bus.rs_a_data;
    assign w_b_raw = w_byp_b ? r_out_d : bus.rs_b_data;
`else
    logic w_unused_addr;

    assign w_unused_addr = ^{bus.rs_a_addr, bus.rs_b_addr};
    assign w_op_a        = bus.rs_a_data;
    assign w_b_raw       = bus.rs_b_data;
`endif

    assign w_imm_ext = {{(XLEN - c_IMM_W){bus.imm[c_IMM_W-1]}}, bus.imm};
    assign w_op_b    = bus.is_imm ? w_imm_ext : w_b_raw;
    assign w_shamt   = w_op_b[c_SH_W-1:0];

    // --------------------------------------------------------------------- ALU
    always_comb begin
        w_alu = '0;
        case (bus.op)
            OP_ADD:   w_alu = w_op_a + w_op_b;
            OP_SUB:   w_alu = w_op_a - w_op_b;
            OP_AND:   w_alu = w_op_a & w_op_b;
            OP_OR:    w_alu = w_op_a | w_op_b;
            OP_XOR:   w_alu = w_op_a ^ w_op_b;
            OP_SLT:   w_alu = {{(XLEN-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
            OP_SLL:   w_alu = w_op_a << w_shamt;
            OP_SRL:   w_alu = w_op_a >> w_shamt;
            OP_SRA:   w_alu = $signed(w_op_a) >>> w_shamt;
            OP_PASSB: w_alu = w_op_b;
            default:  w_alu = '0;
        endcase
    end

    // --------------------------------------------------------------- handshake
    assign w_in_ready  = !w_mul_busy && (!r_out_valid || bus.out_ready);
    assign w_accept    = bus.in_valid && w_in_ready && !bus.flush;
    assign w_is_mul    = (bus.op == OP_MUL);
    assign w_mul_start = w_accept && w_is_mul;

    exec_mul #(
        .XLEN    (XLEN),
        .MUL_LAT (MUL_LAT)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_mul_start),
        .i_flush (bus.flush),
        .i_a     (w_op_a),
        .i_b     (w_op_b),
        .o_busy  (w_mul_busy),
        .o_done  (w_mul_done),
        .o_p     (w_mul_p)
    );

    // ---------------------------------------------------------- result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_d     <= '0;
            r_out_b     <= '0;
            r_out_zero  <= 1'b1;
            r_out_rd    <= '0;
            r_pend_b    <= '0;
            r_pend_rd   <= '0;
        end else begin
            if (w_mul_start) begin
                r_pend_b  <= w_b_raw;
                r_pend_rd <= bus.rd_addr;
            end
            // A MUL acceptance only happens once the old result is consumed,
            // so it lands in the final branch and clears out_valid.
            if (bus.flush) begin
                r_out_valid <= 1'b0;
            end else if (w_accept && !w_is_mul) begin
                r_out_valid <= 1'b1;
                r_out_d     <= w_alu;
                r_out_b     <= w_b_raw;
                r_out_zero  <= (w_alu == '0);
                r_out_rd    <= bus.rd_addr;
            end else if (w_mul_done) begin
                r_out_valid <= 1'b1;
                r_out_d     <= w_mul_p;
                r_out_b     <= r_pend_b;
                r_out_zero  <= (w_mul_p == '0);
                r_out_rd    <= r_pend_rd;
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_d_data = r_out_d;
    assign bus.out_b_data = r_out_b;
    assign bus.out_zero   = r_out_zero;
    assign bus.out_rd     = r_out_rd;
    assign bus.busy       = w_mul_busy;

endmodule

`default_nettype wire

// File: tb/tb_exec_stage.sv
// ============================================================================
// Module   : tb_exec_stage
// Brief    : Directed self-checking bench for exec_stage (XLEN=32, MUL_LAT=3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_exec_stage;
    import exec_pkg::*;

    localparam int XLEN = 32;
    localparam int RAW  = 5;
    localparam int LAT  = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    exec_if #(.XLEN(XLEN), .REG_ADDR_W(RAW)) bus ();

    exec_stage #(
        .XLEN       (XLEN),
        .REG_ADDR_W (RAW),
        .MUL_LAT    (LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Expected architectural state: what the result port must show, plus a
    // multiply in flight with its remaining cycle count.
    bit          m_valid;
    logic [31:0] m_d, m_b;
    logic [4:0]  m_rd;
    int          m_busy;
    logic [31:0] p_d, p_b;
    logic [4:0]  p_rd;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        case (op)
            OP_ADD:   return a + b;
            OP_SUB:   return a - b;
            OP_AND:   return a & b;
            OP_OR:    return a | b;
            OP_XOR:   return a ^ b;
            OP_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLL:   return a << b[4:0];
            OP_SRL:   return a >> b[4:0];
            OP_SRA:   return $unsigned($signed(a) >>> b[4:0]);
            OP_PASSB: return b;
            OP_MUL:   return a * b;
            default:  return 32'd0;
        endcase
    endfunction

    // One clock: check in_ready, advance the model, check every output.
    task automatic cycle();
        logic        rdy, acc, fl;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [31:0] a, braw, b, r;
        #1;
        rdy = (m_busy == 0) && (!m_valid || bus.out_ready);
        chk("in_ready", bus.in_ready, rdy);
        fl   = bus.flush;
        acc  = bus.in_valid && rdy && !fl;
        op   = bus.op;
        rd   = bus.rd_addr;
        a    = bus.rs_a_data;
        braw = bus.rs_b_data;
`ifdef EXEC_BYPASS_EN
        if (m_valid && bus.rs_a_addr != 0 && bus.rs_a_addr == m_rd) a = m_d;
        if (m_valid && bus.rs_b_addr != 0 && bus.rs_b_addr == m_rd) braw = m_d;
`endif
        b = bus.is_imm ? {{16{bus.imm[15]}}, bus.imm} : braw;
        r = ref_alu(op, a, b);
        @(posedge clk);
        if (fl) begin
            m_valid = 0;
            m_busy  = 0;
        end else if (acc && op == OP_MUL) begin
            m_busy = LAT; p_d = r; p_b = braw; p_rd = rd; m_valid = 0;
        end else if (acc) begin
            m_valid = 1; m_d = r; m_b = braw; m_rd = rd;
        end else if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                m_valid = 1; m_d = p_d; m_b = p_b; m_rd = p_rd;
            end
        end else if (m_valid && bus.out_ready) begin
            m_valid = 0;
        end
        #1;
        chk("out_valid", bus.out_valid, m_valid);
        chk("busy", bus.busy, m_busy != 0);
        if (m_valid) begin
            chk("out_d_data", bus.out_d_data, m_d);
            chk("out_b_data", bus.out_b_data, m_b);
            chk("out_zero", bus.out_zero, m_d == 0);
            chk("out_rd", bus.out_rd, m_rd);
        end
    endtask

    task automatic drv(logic [3:0] op, logic [4:0] aa, logic [31:0] ad,
                       logic [4:0] ba, logic [31:0] bd, logic ii,
                       logic [15:0] imm, logic [4:0] rd);
        bus.in_valid  = 1'b1;
        bus.op        = op;
        bus.rs_a_addr = aa;
        bus.rs_a_data = ad;
        bus.rs_b_addr = ba;
        bus.rs_b_data = bd;
        bus.is_imm    = ii;
        bus.imm       = imm;
        bus.rd_addr   = rd;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        logic [3:0]  t_op  [10] = '{OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLT,
                                    OP_SLL, OP_SRL, OP_SRA, OP_PASSB, 4'd15};
        logic [31:0] t_a   [10] = '{32'hF0F0_1234, 32'hF000_0000, 32'hFFFF_0000,
                                    32'hFFFF_FFFF, 32'd5, 32'd1, 32'h8000_0000,
                                    32'h8000_0000, 32'd0, 32'd1};
        logic [31:0] t_b   [10] = '{32'h0FF0_FFFF, 32'h0000_000F, 32'h0F0F_0F0F,
                                    32'd1, 32'h8000_0000, 32'h0000_0023, 32'd4,
                                    32'd4, 32'hDEAD_BEEF, 32'd1};
        logic [31:0] t_exp [10] = '{32'h00F0_1234, 32'hF000_000F, 32'hF0F0_0F0F,
                                    32'd1, 32'd0, 32'd8, 32'h0800_0000,
                                    32'hF800_0000, 32'hDEAD_BEEF, 32'd0};
        int busy_cycles;

        bus.in_valid = 0; bus.op = 0; bus.rs_a_addr = 0; bus.rs_b_addr = 0;
        bus.rs_a_data = 0; bus.rs_b_data = 0; bus.imm = 0; bus.is_imm = 0;
        bus.rd_addr = 0; bus.flush = 0; bus.out_ready = 1;
        m_valid = 0; m_busy = 0; m_d = 0; m_b = 0; m_rd = 0;
        p_d = 0; p_b = 0; p_rd = 0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_out_d", bus.out_d_data, 0);
        chk("rst_out_b", bus.out_b_data, 0);
        chk("rst_out_zero", bus.out_zero, 1);
        chk("rst_out_rd", bus.out_rd, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", bus.in_ready, 1);

        // ADD 5+7
        drv(OP_ADD, 5'd1, 32'd5, 5'd2, 32'd7, 1'b0, 16'h0, 5'd1);
        cycle();
        chk("add_valid", bus.out_valid, 1);
        chk("add_d", bus.out_d_data, 32'd12);
        chk("add_zero", bus.out_zero, 0);

        // Immediate forms
        drv(OP_SUB, 5'd1, 32'd9, 5'd2, 32'd0, 1'b1, 16'h0009, 5'd2);
        cycle();
        chk("subi_d", bus.out_d_data, 32'd0);
        chk("subi_zero", bus.out_zero, 1);
        drv(OP_ADD, 5'd1, 32'd1, 5'd2, 32'h55, 1'b1, 16'hFFFF, 5'd3);
        cycle();
        chk("addi_neg_d", bus.out_d_data, 32'd0);
        chk("addi_store_b", bus.out_b_data, 32'h55);

        // Streaming op table
        for (int i = 0; i < 10; i++) begin
            drv(t_op[i], 5'd0, t_a[i], 5'd0, t_b[i], 1'b0, 16'h0, 5'(i + 5));
            cycle();
            chk("op_table", bus.out_d_data, t_exp[i]);
        end
        idle();
        cycle();
        chk("drain_valid", bus.out_valid, 0);

        // MUL with the next instruction held
        drv(OP_MUL, 5'd0, 32'd3, 5'd0, 32'd4, 1'b0, 16'h0, 5'd6);
        cycle();
        drv(OP_ADD, 5'd0, 32'd2, 5'd0, 32'd2, 1'b0, 16'h0, 5'd7);
        busy_cycles = 0;
        for (int i = 0; i < LAT; i++) begin
            if (bus.busy && !bus.in_ready) busy_cycles++;
            cycle();
        end
        chk("mul_busy_cycles", busy_cycles, LAT);
        chk("mul_d", bus.out_d_data, 32'd12);
        chk("mul_rd", bus.out_rd, 32'd6);
        cycle();
        chk("after_mul_d", bus.out_d_data, 32'd4);
        idle();
        cycle();

        // Forwarding
        drv(OP_ADD, 5'd0, 32'd1, 5'd0, 32'd1, 1'b0, 16'h0, 5'd3);
        cycle();
        drv(OP_ADD, 5'd3, 32'd0, 5'd3, 32'd0, 1'b0, 16'h0, 5'd4);
        cycle();
`ifdef EXEC_BYPASS_EN
        chk("bypass_d", bus.out_d_data, 32'd4);
`else
        chk("bypass_d", bus.out_d_data, 32'd0);
`endif
        drv(OP_ADD, 5'd0, 32'd5, 5'd0, 32'd5, 1'b0, 16'h0, 5'd0);
        cycle();
        chk("r0_result_rd", bus.out_rd, 0);
        drv(OP_ADD, 5'd0, 32'd1, 5'd0, 32'd1, 1'b0, 16'h0, 5'd8);
        cycle();
        chk("r0_no_bypass", bus.out_d_data, 32'd2);
        idle();
        cycle();

        // Back-pressure
        drv(OP_ADD, 5'd0, 32'd20, 5'd0, 32'd22, 1'b0, 16'h0, 5'd9);
        cycle();
        bus.out_ready = 1'b0;
        drv(OP_ADD, 5'd0, 32'd1, 5'd0, 32'd1, 1'b0, 16'h0, 5'd10);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("bp_hold_d", bus.out_d_data, 32'd42);
            chk("bp_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        cycle();
        chk("bp_next_d", bus.out_d_data, 32'd2);
        chk("bp_next_rd", bus.out_rd, 32'd10);
        idle();
        cycle();

        // Flush mid-MUL
        drv(OP_MUL, 5'd0, 32'd5, 5'd0, 32'd6, 1'b0, 16'h0, 5'd11);
        cycle();
        idle();
        cycle();
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0;
        chk("flush_busy", bus.busy, 0);
        repeat (LAT + 1) cycle();
        chk("flush_no_result", bus.out_valid, 0);
        drv(OP_ADD, 5'd0, 32'd3, 5'd0, 32'd4, 1'b0, 16'h0, 5'd12);
        cycle();
        chk("flush_next_d", bus.out_d_data, 32'd7);

        // Flush beats a simultaneous transfer
        drv(OP_ADD, 5'd0, 32'd9, 5'd0, 32'd9, 1'b0, 16'h0, 5'd13);
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0;
        idle();
        chk("flush_drop", bus.out_valid, 0);
        cycle();

        // Reset mid-MUL
        drv(OP_MUL, 5'd0, 32'd7, 5'd0, 32'd8, 1'b0, 16'h0, 5'd14);
        cycle();
        idle();
        cycle();
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_valid", bus.out_valid, 0);
        chk("midrst_zero", bus.out_zero, 1);
        m_valid = 0;
        m_busy  = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT + 2) cycle();
        chk("midrst_no_result", bus.out_valid, 0);
        drv(OP_ADD, 5'd0, 32'd10, 5'd0, 32'd5, 1'b0, 16'h0, 5'd15);
        cycle();
        chk("midrst_next_d", bus.out_d_data, 32'd15);
        idle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
